// File: rtl/sha256_pkg.sv
// sha256_pkg: round constants, initial hash value, SHA-256 round functions
// and the engine state type shared by the round engine and its datapath.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Word j at [32j+31:32j]; H0 in the low word.
  localparam logic [255:0] IV_HASH = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round_engine_if.sv
// sha256_round_engine_if: request/response bundle between a block source
// and the SHA-256 round engine (master drives requests, slave is the engine).
interface sha256_round_engine_if;
  logic         start;
  logic [511:0] block;
  logic [255:0] init_hash;
  logic         busy;
  logic         done;
  logic [255:0] working_hash;

  modport master (
    output start, block, init_hash,
    input  busy, done, working_hash
  );

  modport slave (
    input  start, block, init_hash,
    output busy, done, working_hash
  );
endinterface

// File: rtl/sha256_round.sv
// sha256_round: purely combinational single SHA-256 round.
// State packing: word 0 (a) in [31:0] up to word 7 (h) in [255:224].
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] i_state,
  input  logic [31:0]  i_k,
  input  logic [31:0]  i_w,
  output logic [255:0] o_state
);
  logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0] w_t1, w_t2;

  assign w_a = i_state[31:0];
  assign w_b = i_state[63:32];
  assign w_c = i_state[95:64];
  assign w_d = i_state[127:96];
  assign w_e = i_state[159:128];
  assign w_f = i_state[191:160];
  assign w_g = i_state[223:192];
  assign w_h = i_state[255:224];

  assign w_t1 = w_h + big_sigma1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
  assign w_t2 = big_sigma0(w_a) + maj(w_a, w_b, w_c);

  // New h..a = g, f, e, d+T1, c, b, a, T1+T2 (MSB word first).
  assign o_state = {w_g, w_f, w_e, w_d + w_t1, w_c, w_b, w_a, w_t1 + w_t2};
endmodule

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: iterative SHA-256 compression of one 512-bit block
// from a supplied chaining value. Presents a..h after round 63 with a
// one-cycle done strobe; feed-forward addition is left to the next stage.
// Build option: define SHA256_TWO_ROUND_EN to run two chained rounds per
// cycle (32-cycle latency); undefined runs one round per cycle.
module sha256_round_engine
  import sha256_pkg::*;
(
  input logic                  clock,
  input logic                  reset,
  sha256_round_engine_if.slave bus
);

`ifdef SHA256_TWO_ROUND_EN
  localparam int         STEP_N = 2;
  localparam logic [5:0] STEP   = 6'd2;
  localparam logic [5:0] LAST_T = 6'd62;
`else
  localparam int         STEP_N = 1;
  localparam logic [5:0] STEP   = 6'd1;
  localparam logic [5:0] LAST_T = 6'd63;
`endif

  state_t       r_state, w_state_nxt;
  logic [5:0]   r_t;
  logic [255:0] r_wv;
  logic [31:0]  r_w [16];

  logic         w_accept;
  logic         w_last;
  logic [255:0] w_round_out;
  logic [31:0]  w_new0;

  assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_t == LAST_T);

  // Window holds W[t..t+15] in r_w[0..15]; this is W[t+16].
  assign w_new0 = small_sigma1(r_w[14]) + r_w[9] + small_sigma0(r_w[1]) + r_w[0];

`ifdef SHA256_TWO_ROUND_EN
  logic [255:0] w_mid;
  logic [31:0]  w_new1;
  logic [5:0]   w_t_odd;

  assign w_t_odd = r_t + 6'd1;
  // W[t+17] uses the window directly since W[t+15] is already present.
  assign w_new1  = small_sigma1(r_w[15]) + r_w[10] + small_sigma0(r_w[2]) + r_w[1];

  sha256_round u_round0 (
    .i_state (r_wv),
    .i_k     (K[r_t]),
    .i_w     (r_w[0]),
    .o_state (w_mid)
  );

  sha256_round u_round1 (
    .i_state (w_mid),
    .i_k     (K[w_t_odd]),
    .i_w     (r_w[1]),
    .o_state (w_round_out)
  );
`else
  sha256_round u_round0 (
    .i_state (r_wv),
    .i_k     (K[r_t]),
    .i_w     (r_w[0]),
    .o_state (w_round_out)
  );
`endif

  // State register; reset aborts any run in progress.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: a start in DONE chains straight into the next block.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = ROUND;
      ROUND:   if (w_last)    w_state_nxt = DONE;
      DONE:    w_state_nxt = bus.start ? ROUND : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Load on an accepted start, otherwise advance rounds and schedule in ROUND.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wv <= '0;
      r_t  <= '0;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else if (w_accept) begin
      r_wv <= bus.init_hash;
      r_t  <= '0;
      for (int i = 0; i < 16; i++) r_w[i] <= bus.block[511 - 32*i -: 32];
    end else if (r_state == ROUND) begin
      r_wv <= w_round_out;
      r_t  <= r_t + STEP;
      for (int i = 0; i < 16 - STEP_N; i++) r_w[i] <= r_w[i + STEP_N];
`ifdef SHA256_TWO_ROUND_EN
      r_w[14] <= w_new0;
      r_w[15] <= w_new1;
`else
      r_w[15] <= w_new0;
`endif
    end
  end

  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = (r_state == DONE);
  assign bus.working_hash = r_wv;

endmodule
